// File: rtl/mips_exec_unit.sv
`default_nettype none
// ============================================================================
// Module  : mips_exec_unit
// Brief   : MIPS execute stage: ALU-control decode, registered 32-bit ALU,
//           PC+4 and branch-target adders.
// Revision: 1.0 - initial release
// ============================================================================
module mips_exec_unit #(
  parameter int WIDTH  = 32,
  parameter int PC_INC = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en_i,
  input  logic [1:0]       alu_op_i,
  input  logic [5:0]       funct_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic [WIDTH-1:0] pc_i,
  input  logic [WIDTH-1:0] imm_ext_i,
  output logic [3:0]       alu_ctrl_o,
  output logic [WIDTH-1:0] alu_result_o,
  output logic             zero_o,
  output logic [WIDTH-1:0] pc_plus4_o,
  output logic [WIDTH-1:0] branch_target_o
);

  localparam logic [3:0] C_AND = 4'b0000;
  localparam logic [3:0] C_OR  = 4'b0001;
  localparam logic [3:0] C_ADD = 4'b0010;
  localparam logic [3:0] C_SUB = 4'b0110;
  localparam logic [3:0] C_SLT = 4'b0111;
  localparam logic [3:0] C_NOR = 4'b1100;
  localparam logic [3:0] C_INV = 4'b1111;

  logic [3:0]       w_alu_ctrl;
  logic [WIDTH-1:0] w_alu_d;
  logic [WIDTH-1:0] r_alu_result_q;
  logic             r_zero_q;

  always_comb begin
    w_alu_ctrl = C_INV;
    case (alu_op_i)
      2'b00:   w_alu_ctrl = C_ADD;
      2'b01:   w_alu_ctrl = C_SUB;
      2'b11:   w_alu_ctrl = C_ADD;
      default: begin
        case (funct_i)
          6'b100000: w_alu_ctrl = C_ADD;
          6'b100010: w_alu_ctrl = C_SUB;
          6'b100100: w_alu_ctrl = C_AND;
          6'b100101: w_alu_ctrl = C_OR;
          6'b100111: w_alu_ctrl = C_NOR;
          6'b101010: w_alu_ctrl = C_SLT;
          default:   w_alu_ctrl = C_INV;
        endcase
      end
    endcase
  end

  // Unassigned codes (including the invalid marker) produce zero.
  always_comb begin
    w_alu_d = '0;
    case (w_alu_ctrl)
      C_AND:   w_alu_d = a_i & b_i;
      C_OR:    w_alu_d = a_i | b_i;
      C_ADD:   w_alu_d = a_i + b_i;
      C_SUB:   w_alu_d = a_i - b_i;
      C_NOR:   w_alu_d = ~(a_i | b_i);
      C_SLT:   w_alu_d = {{(WIDTH-1){1'b0}}, ($signed(a_i) < $signed(b_i))};
      default: w_alu_d = '0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_alu_result_q <= '0;
      r_zero_q       <= 1'b0;
    end else if (en_i) begin
      r_alu_result_q <= w_alu_d;
      r_zero_q       <= (w_alu_d == '0);
    end
  end

  assign alu_ctrl_o      = w_alu_ctrl;
  assign alu_result_o    = r_alu_result_q;
  assign zero_o          = r_zero_q;
  assign pc_plus4_o      = pc_i + WIDTH'(PC_INC);
  assign branch_target_o = pc_plus4_o + {imm_ext_i[WIDTH-3:0], 2'b00};

endmodule
`default_nettype wire

// File: tb/tb_mips_exec_unit.sv
`default_nettype none
// ============================================================================
// Module  : tb_mips_exec_unit
// Brief   : Randomised scoreboard bench for mips_exec_unit.
// Revision: 1.0 - initial release
// ============================================================================
module tb_mips_exec_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b0;
  logic [1:0]  alu_op = 2'b00;
  logic [5:0]  funct = 6'd0;
  logic [31:0] a = '0, b = '0, pc = '0, imm = '0;
  logic [3:0]  alu_ctrl;
  logic [31:0] alu_result, pc_plus4, branch_target;
  logic        zero;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct { logic [31:0] res; logic z; string tag; } exp_t;
  exp_t sb_q[$];

  logic [31:0] m_res = '0;
  logic        m_zero = 1'b0;

  always #5 clk = ~clk;

  mips_exec_unit #(.WIDTH(32), .PC_INC(4)) dut (
    .clk(clk), .rst(rst), .en_i(en), .alu_op_i(alu_op), .funct_i(funct),
    .a_i(a), .b_i(b), .pc_i(pc), .imm_ext_i(imm),
    .alu_ctrl_o(alu_ctrl), .alu_result_o(alu_result), .zero_o(zero),
    .pc_plus4_o(pc_plus4), .branch_target_o(branch_target)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  // Instruction-level reference: name the operation, then apply it.
  function automatic string op_name(input logic [1:0] op, input logic [5:0] f);
    if (op == 2'b00 || op == 2'b11) return "add";
    if (op == 2'b01) return "sub";
    case (f)
      6'h20: return "add";
      6'h22: return "sub";
      6'h24: return "and";
      6'h25: return "or";
      6'h27: return "nor";
      6'h2a: return "slt";
      default: return "inv";
    endcase
  endfunction

  function automatic logic [3:0] op_code(input string n);
    case (n)
      "add": return 4'h2;
      "sub": return 4'h6;
      "and": return 4'h0;
      "or":  return 4'h1;
      "nor": return 4'hc;
      "slt": return 4'h7;
      default: return 4'hf;
    endcase
  endfunction

  function automatic logic [31:0] op_eval(input string n, input logic [31:0] x, input logic [31:0] y);
    longint sx, sy;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    case (n)
      "add": return 32'((longint'(x) + longint'(y)) % (64'd1 << 32));
      "sub": return 32'((longint'(x) - longint'(y) + (64'd1 << 32)) % (64'd1 << 32));
      "and": return x & y;
      "or":  return x | y;
      "nor": return ~(x | y);
      "slt": return (sx < sy) ? 32'd1 : 32'd0;
      default: return 32'd0;
    endcase
  endfunction

  // One clock of stimulus; combinational outputs are checked here, the
  // registered response goes to the scoreboard for the monitor.
  task automatic cycle(input logic e, input logic [1:0] op, input logic [5:0] f,
                       input logic [31:0] x, input logic [31:0] y,
                       input logic [31:0] p, input logic [31:0] im, input string tag);
    exp_t it;
    string n;
    longint bt;
    @(negedge clk);
    en = e; alu_op = op; funct = f; a = x; b = y; pc = p; imm = im;
    #1;
    n = op_name(op, f);
    check({tag, ".ctrl"}, {28'd0, alu_ctrl}, {28'd0, op_code(n)});
    check({tag, ".pc4"}, pc_plus4, 32'((longint'(p) + 4) % (64'd1 << 32)));
    bt = (longint'(p) + 4 + 4 * longint'($signed(im))) % (64'd1 << 32);
    if (bt < 0) bt += (64'd1 << 32);
    check({tag, ".bt"}, branch_target, 32'(bt));
    if (e) begin
      m_res  = op_eval(n, x, y);
      m_zero = (m_res == 0);
    end
    it.res = m_res; it.z = m_zero; it.tag = tag;
    sb_q.push_back(it);
  endtask

  initial begin : monitor
    exp_t it;
    forever begin
      @(posedge clk);
      #1;
      if (sb_q.size() > 0) begin
        it = sb_q.pop_front();
        check({it.tag, ".res"}, alu_result, it.res);
        check({it.tag, ".zero"}, {31'd0, zero}, {31'd0, it.z});
      end
    end
  end

  initial begin : stim
    logic [5:0] fl [8];
    fl[0] = 6'h20; fl[1] = 6'h22; fl[2] = 6'h24; fl[3] = 6'h25;
    fl[4] = 6'h27; fl[5] = 6'h2a; fl[6] = 6'h00; fl[7] = 6'h3f;

    repeat (2) @(posedge clk);
    #1;
    check("reset.res", alu_result, 32'd0);
    check("reset.zero", {31'd0, zero}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    cycle(1, 2'b10, 6'h20, 32'd5, 32'd3, 32'd0, 32'd3, "add5_3");
    cycle(1, 2'b10, 6'h24, 32'h0000ffff, 32'h00ff00ff, 32'h0, 32'h3, "and");
    cycle(1, 2'b10, 6'h25, 32'h0000ffff, 32'h00ff00ff, 32'h10, 32'hfffffffe, "or");
    cycle(1, 2'b10, 6'h27, 32'h0000ffff, 32'h00ff00ff, 32'hfffffffc, 32'h0, "nor");
    cycle(1, 2'b10, 6'h22, 32'h0000ffff, 32'h00ff00ff, 32'h100, 32'h8000, "sub");
    cycle(1, 2'b01, 6'h00, 32'h12345678, 32'h12345678, 32'h4, 32'h1, "beq_eq");
    cycle(1, 2'b01, 6'h00, 32'h12345678, 32'h12345679, 32'h4, 32'h1, "beq_ne");
    cycle(1, 2'b10, 6'h2a, 32'hffffffff, 32'h00000001, 32'h0, 32'h0, "slt_neg");
    cycle(1, 2'b10, 6'h2a, 32'h00000001, 32'hffffffff, 32'h0, 32'h0, "slt_pos");
    cycle(1, 2'b10, 6'h00, 32'h00000007, 32'h00000009, 32'h0, 32'h0, "invalid");
    cycle(1, 2'b10, 6'h20, 32'd1, 32'd2, 32'h0, 32'h0, "pre_hold");
    cycle(0, 2'b10, 6'h20, 32'd100, 32'd200, 32'h0, 32'h0, "hold1");
    cycle(0, 2'b11, 6'h22, 32'd7, 32'd9, 32'h0, 32'h0, "hold2");
    cycle(1, 2'b00, 6'h00, 32'hffffffff, 32'h00000001, 32'h0, 32'h0, "wrap");
    cycle(1, 2'b11, 6'h24, 32'h80000000, 32'h80000000, 32'h0, 32'h0, "op11");

    // Reset between edges with a pending capture: must clear at once and
    // discard the operation that was set up.
    @(negedge clk);
    en = 1'b1; alu_op = 2'b10; funct = 6'h25; a = 32'hdead0000; b = 32'h0000beef;
    #2 rst = 1'b1;
    #1;
    check("midrst.res", alu_result, 32'd0);
    check("midrst.zero", {31'd0, zero}, 32'd0);
    @(posedge clk);
    #1;
    check("rsthold.res", alu_result, 32'd0);
    check("rsthold.zero", {31'd0, zero}, 32'd0);
    @(negedge clk);
    en = 1'b0;
    rst = 1'b0;
    m_res = '0;
    m_zero = 1'b0;
    cycle(0, 2'b10, 6'h20, 32'd4, 32'd4, 32'h0, 32'h0, "postrst_hold");
    cycle(1, 2'b10, 6'h20, 32'd4, 32'd4, 32'h0, 32'h0, "postrst_cap");

    for (int i = 0; i < 300; i++) begin
      logic [31:0] x, y;
      x = $urandom();
      y = ($urandom_range(0, 7) == 0) ? x : $urandom();
      if ($urandom_range(0, 9) == 0) x = 32'hffffffff;
      cycle(($urandom_range(0, 4) != 0), 2'($urandom_range(0, 3)),
            ($urandom_range(0, 5) == 0) ? 6'($urandom()) : fl[$urandom_range(0, 7)],
            x, y, $urandom(), $urandom(), "rand");
    end

    for (int t = 0; t < 10 && sb_q.size() > 0; t++) @(posedge clk);
    @(posedge clk);
    #2;
    check("sb_drained", sb_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
